// File: rtl/line_mem_scheduler.sv
// Arbitrates the single cacheline adaptor port among the data cache, instruction cache and
// next-line prefetcher (D > I > PF, with bounded starvation of I behind D).
module line_mem_scheduler #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fls_i,

  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i,

  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              d_resp_o,

  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [LINE_W-1:0] i_rdata_o,
  output logic              i_resp_o,

  input  logic              pf_req_i,
  input  logic [ADDR_W-1:0] pf_addr_i,
  output logic              pf_ack_o,
  output logic              pf_done_o,
  output logic [LINE_W-1:0] pf_rdata_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 2);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StBusyD, StBusyI, StBusyPf} state_e;

  state_e          state_q;
  logic [CntW-1:0] starve_q;
  logic            discard_q;

  logic grant_d, grant_i, grant_pf;

  always_comb begin
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    grant_pf = 1'b0;
    if (state_q == StIdle) begin
      if (i_read_i && (starve_q == StarveMax)) begin
        grant_i = 1'b1;
      end else if (d_read_i || d_write_i) begin
        grant_d = 1'b1;
      end else if (i_read_i) begin
        grant_i = 1'b1;
      end else if (pf_req_i && !fls_i) begin
        grant_pf = 1'b1;
      end
    end
  end

  assign pf_ack_o  = grant_pf & ~rst;
  assign d_resp_o  = (state_q == StBusyD) & mem_resp_i;
  assign i_resp_o  = (state_q == StBusyI) & mem_resp_i;
  // A flush in the completing cycle also suppresses delivery, not just an earlier one.
  assign pf_done_o = (state_q == StBusyPf) & mem_resp_i & ~discard_q & ~fls_i;

  assign d_rdata_o  = mem_rdata_i;
  assign i_rdata_o  = mem_rdata_i;
  assign pf_rdata_o = mem_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      discard_q   <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q     <= StBusyD;
            mem_write_o <= d_write_i;
            mem_read_o  <= ~d_write_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            if (!i_read_i) begin
              starve_q <= '0;
            end else if (starve_q != StarveMax) begin
              starve_q <= starve_q + 1'b1;
            end
          end else if (grant_i) begin
            state_q     <= StBusyI;
            mem_read_o  <= 1'b1;
            mem_write_o <= 1'b0;
            mem_addr_o  <= i_addr_i;
            mem_wdata_o <= '0;
            starve_q    <= '0;
          end else if (grant_pf) begin
            state_q     <= StBusyPf;
            mem_read_o  <= 1'b1;
            mem_write_o <= 1'b0;
            mem_addr_o  <= pf_addr_i;
            mem_wdata_o <= '0;
            starve_q    <= '0;
          end else if (!i_read_i) begin
            starve_q <= '0;
          end
        end
        StBusyD, StBusyI, StBusyPf: begin
          // The adaptor cannot abort, so a flush only marks the prefetch line as unwanted.
          if ((state_q == StBusyPf) && fls_i) begin
            discard_q <= 1'b1;
          end
          if (mem_resp_i) begin
            state_q     <= StIdle;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            discard_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read_i && d_write_i))
    else $error("data cache asserted read and write together");
`endif

endmodule

// File: doc/line_mem_scheduler.md
Name: line_mem_scheduler

Overview:
- Schedules the single 256-bit cacheline memory port, i.e. the cacheline adaptor, among three requesters: the data cache (read/write), the instruction cache (read) and a next-line prefetcher (read only).
- Sits between the two L1 caches plus prefetcher and the cacheline adaptor.
- Priority order is D > I > PF, with bounded starvation for I.
- Flush (fls_i) cancels pending and in-flight prefetch delivery.

Parameters:
- STARVE_MAX, 4: maximum consecutive D grants while I is waiting; after that, I is forced.
- ADDR_W, 32: address width.
- LINE_W, 256: cacheline width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fls_i  in  1  pipeline flush; drops prefetch work
- mem_read_o  out  1  read request to adaptor
- mem_write_o  out  1  write request to adaptor
- mem_addr_o  out  ADDR_W  line address to adaptor
- mem_wdata_o  out  LINE_W  write line to adaptor
- mem_rdata_i  in  LINE_W  read line from adaptor
- mem_resp_i  in  1  adaptor completion
- d_read_i, d_write_i  in  1  data cache request
- d_addr_i  in  ADDR_W  data cache address
- d_wdata_i  in  LINE_W  data cache writeback line
- d_rdata_o  out  LINE_W  line returned to data cache
- d_resp_o  out  1  data cache completion
- i_read_i  in  1  instruction cache request
- i_addr_i  in  ADDR_W  instruction cache address
- i_rdata_o  out  LINE_W  line returned to instruction cache
- i_resp_o  out  1  instruction cache completion
- pf_req_i  in  1  prefetch request
- pf_addr_i  in  ADDR_W  prefetch address
- pf_ack_o  out  1  one-cycle pulse: prefetch accepted
- pf_done_o  out  1  one-cycle pulse: prefetch line valid
- pf_rdata_o  out  LINE_W  prefetched line

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- States: IDLE, BUSY_D, BUSY_I, BUSY_PF.
- Reset:
  - state=IDLE, starve_cnt=0, discard=0.
  - Registered address/wdata/op cleared.
  - mem_read_o=mem_write_o=0, all resp/ack/done outputs 0, mem_addr_o/mem_wdata_o=0.
- Grant (IDLE only, cycle T):
  - If i_read_i && starve_cnt==STARVE_MAX: grant I.
  - Else if d_read_i|d_write_i: grant D.
  - Else if i_read_i: grant I.
  - Else if pf_req_i && !fls_i: grant PF and pulse pf_ack_o at T.
  - Otherwise stay in IDLE.
- On grant: register addr, wdata and op (D: write if d_write_i, else read). Enter BUSY_x at T+1.
  - d_read_i && d_write_i together is illegal: write wins, simulation assertion fires.
- BUSY_x:
  - mem_read_o/mem_write_o are driven from registered state starting at T+1.
  - Held constant until mem_resp_i; address and wdata are stable throughout.
  - Requester inputs are ignored while busy; requesters hold their request until their resp.
- Completion, in the cycle mem_resp_i=1:
  - BUSY_D: d_resp_o=1 (combinational).
  - BUSY_I: i_resp_o=1.
  - BUSY_PF: pf_done_o=1 only if !discard && !fls_i.
  - x_rdata_o = mem_rdata_i (passthrough; all three rdata outputs may carry it, resp qualifies).
  - Next state IDLE; mem_read/write drop the next cycle.
- Turnaround: IDLE lasts at least one cycle between transactions. A requester that received resp at cycle k must have deasserted by k+1.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each D grant while i_read_i=1.
  - Cleared on an I grant, or in IDLE with i_read_i=0.
- Flush:
  - fls_i in BUSY_PF sets discard. The memory transaction completes normally (the adaptor cannot abort), but pf_done_o is suppressed.
  - discard clears on return to IDLE.
  - fls_i has no effect on D/I transactions.
- Reset mid-transaction: returns to IDLE next cycle with outputs cleared. The adaptor shares rst.
- Latency (idle, no contention): request at T → mem op at T+1 → resp same cycle as mem_resp_i. Minimum 2 cycles.

Test Plan:
- D read only, addr 0x0000_1000; adaptor resps at T+5 with line 0xA5..A5 → mem_read_o high T+1..T+5, d_resp_o=1 at T+5, d_rdata_o=0xA5..A5, i_resp_o=0.
- D and I request simultaneously every cycle, D reissuing immediately, STARVE_MAX=4 → grant sequence D,D,D,D,I; I served on the 5th transaction, and starve_cnt returns to 0.
- D write of addr 0x40, wdata pattern 0x0123..; I idle → mem_write_o=1 with mem_addr_o=0x40 and mem_wdata_o equal to the pattern, stable until resp; d_resp_o pulses once.
- pf_req_i with pf_addr 0x80, no demand → pf_ack_o at T, mem_read_o at T+1; on resp, pf_done_o=1 with data. Repeat with fls_i pulsed at T+2 → transaction completes, pf_done_o stays 0.
- pf_req_i and i_read_i at the same cycle → I granted, pf_ack_o=0. PF is granted only after I completes and IDLE sees no demand.
- rst asserted in BUSY_D before resp → next cycle state IDLE, mem_read_o=0, d_resp_o=0, starve_cnt=0.
